count_glyph_stream: RTL and testbench

- Holds the game's move counter and renders the current digit as a GLYPH_W x GLYPH_H bitmap.
- The bitmap is generated procedurally from seven-segment geometry rather than stored as a fixed constant image.
- Rows stream one per handshake to the display driver's tile compositor.
- Replaces fixed per-digit image constants with one parametrised, size-independent generator.

---
 rtl/count_glyph_stream.sv | 189 ++++++++++++++++++
 tb/tb_count_glyph_stream.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_glyph_stream.sv
// Move counter plus a seven-segment glyph renderer that streams one bitmap row per handshake.
// Rows are computed from segment geometry, so any glyph size with room for the margin works.
module count_glyph_stream #(
   parameter int unsigned GLYPH_W   = 25,
   parameter int unsigned GLYPH_H   = 25,
   parameter int unsigned MARGIN    = 3,
   parameter int unsigned MAX_COUNT = 9,
   localparam int unsigned IdxW     = $clog2(GLYPH_H)
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                incr_i,
   input  logic                clear_i,
   input  logic                start_i,
   input  logic                row_ready_i,
   output logic [3:0]          count_o,
   output logic                wrap_o,
   output logic                busy_o,
   output logic                row_valid_o,
   output logic [GLYPH_W-1:0]  row_data_o,
   output logic [IdxW-1:0]     row_idx_o,
   output logic                row_last_o,
   output logic                frame_done_o
);

   localparam int unsigned ColL = MARGIN;
   localparam int unsigned ColR = GLYPH_W - 1 - MARGIN;
   localparam int unsigned RowT = MARGIN;
   localparam int unsigned RowB = GLYPH_H - 1 - MARGIN;
   localparam int unsigned RowM = GLYPH_H / 2;
   localparam logic [GLYPH_W-1:0] MsbOne = {1'b1, {(GLYPH_W-1){1'b0}}};

   if (GLYPH_W < 2 * MARGIN + 3) begin : g_bad_width
      $error("GLYPH_W too small for MARGIN");
   end
   if (GLYPH_H < 2 * MARGIN + 3) begin : g_bad_height
      $error("GLYPH_H too small for MARGIN");
   end
   if (MAX_COUNT > 9) begin : g_bad_max
      $error("MAX_COUNT must not exceed 9");
   end

   typedef enum logic [0:0] {StIdle, StStream} state_e;

   state_e              state_q, state_d;
   logic [3:0]          count_q, count_d;
   logic                wrap_q, wrap_d;
   logic [3:0]          digit_q, digit_d;
   logic                row_valid_q, row_valid_d;
   logic [GLYPH_W-1:0]  row_data_q, row_data_d;
   logic [IdxW-1:0]     row_idx_q, row_idx_d;
   logic                row_last_q, row_last_d;
   logic                frame_done_q, frame_done_d;
   logic [3:0]          rnd_digit;
   logic [IdxW-1:0]     rnd_row;
   logic [GLYPH_W-1:0]  rnd_data;

   // Segment order {a,b,c,d,e,f,g}; 0 in row_data means a lit pixel.
   function automatic logic [GLYPH_W-1:0] render(input logic [3:0] dig,
                                                 input logic [IdxW-1:0] row);
      logic [6:0]         seg;
      logic [GLYPH_W-1:0] bits;
      int unsigned        y;
      logic               lit;
      case (dig)
         4'd0:    seg = 7'b1111110;
         4'd1:    seg = 7'b0110000;
         4'd2:    seg = 7'b1101101;
         4'd3:    seg = 7'b1111001;
         4'd4:    seg = 7'b0110011;
         4'd5:    seg = 7'b1011011;
         4'd6:    seg = 7'b1011111;
         4'd7:    seg = 7'b1110000;
         4'd8:    seg = 7'b1111111;
         4'd9:    seg = 7'b1111011;
         default: seg = 7'b0000000;
      endcase
      y    = 32'(row);
      bits = '1;
      for (int unsigned x = 0; x < GLYPH_W; x++) begin
         lit = (seg[6] && y == RowT && x >= ColL && x <= ColR) ||
               (seg[0] && y == RowM && x >= ColL && x <= ColR) ||
               (seg[3] && y == RowB && x >= ColL && x <= ColR) ||
               (seg[1] && x == ColL && y >= RowT && y <= RowM) ||
               (seg[5] && x == ColR && y >= RowT && y <= RowM) ||
               (seg[2] && x == ColL && y >= RowM && y <= RowB) ||
               (seg[4] && x == ColR && y >= RowM && y <= RowB);
         if (lit) begin
            bits = bits & ~(MsbOne >> x);
         end
      end
      return bits;
   endfunction

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (clear_i) begin
         count_d = '0;
      end else if (incr_i) begin
         if (count_q == 4'(MAX_COUNT)) begin
            count_d = '0;
            wrap_d  = 1'b1;
         end else begin
            count_d = count_q + 4'd1;
         end
      end
   end

   // One renderer shared between the first row (from count) and later rows (from the snapshot).
   always_comb begin
      rnd_digit = (state_q == StIdle) ? count_q : digit_q;
      rnd_row   = (state_q == StIdle) ? '0 : row_idx_q + 1'b1;
      rnd_data  = render(rnd_digit, rnd_row);
   end

   always_comb begin
      state_d      = state_q;
      digit_d      = digit_q;
      row_valid_d  = row_valid_q;
      row_data_d   = row_data_q;
      row_idx_d    = row_idx_q;
      row_last_d   = row_last_q;
      frame_done_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d     = StStream;
               digit_d     = count_q;
               row_valid_d = 1'b1;
               row_idx_d   = '0;
               row_data_d  = rnd_data;
               row_last_d  = 1'b0;
            end
         end
         StStream: begin
            if (row_ready_i) begin
               if (row_last_q) begin
                  state_d      = StIdle;
                  row_valid_d  = 1'b0;
                  row_idx_d    = '0;
                  row_data_d   = '1;
                  row_last_d   = 1'b0;
                  frame_done_d = 1'b1;
               end else begin
                  row_idx_d  = rnd_row;
                  row_data_d = rnd_data;
                  row_last_d = (rnd_row == IdxW'(GLYPH_H - 1));
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         count_q      <= '0;
         wrap_q       <= 1'b0;
         digit_q      <= '0;
         row_valid_q  <= 1'b0;
         row_data_q   <= '1;
         row_idx_q    <= '0;
         row_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         wrap_q       <= wrap_d;
         digit_q      <= digit_d;
         row_valid_q  <= row_valid_d;
         row_data_q   <= row_data_d;
         row_idx_q    <= row_idx_d;
         row_last_q   <= row_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign count_o      = count_q;
   assign wrap_o       = wrap_q;
   assign busy_o       = (state_q == StStream);
   assign row_valid_o  = row_valid_q;
   assign row_data_o   = row_data_q;
   assign row_idx_o    = row_idx_q;
   assign row_last_o   = row_last_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_count_glyph_stream.sv
// Bench for count_glyph_stream: expected rows come from an independent geometry model and are
// queued when a frame is requested, then popped as the DUT hands each row over.
module tb_count_glyph_stream;

   localparam int W  = 25;
   localparam int H  = 25;
   localparam int MG = 3;
   localparam int IW = 5;

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [W-1:0]  data;
      logic          last;
   } row_t;

   logic          clk, reset, incr, clear, start, row_ready;
   logic [3:0]    count;
   logic          wrap, busy, row_valid, row_last, frame_done;
   logic [W-1:0]  row_data;
   logic [IW-1:0] row_idx;

   row_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   count_glyph_stream #(
      .GLYPH_W  (W),
      .GLYPH_H  (H),
      .MARGIN   (MG),
      .MAX_COUNT(9)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .incr_i      (incr),
      .clear_i     (clear),
      .start_i     (start),
      .row_ready_i (row_ready),
      .count_o     (count),
      .wrap_o      (wrap),
      .busy_o      (busy),
      .row_valid_o (row_valid),
      .row_data_o  (row_data),
      .row_idx_o   (row_idx),
      .row_last_o  (row_last),
      .frame_done_o(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bit d of each table says whether that segment is on for digit d.
   function automatic bit seg_on(logic [9:0] tab, int dig);
      logic [9:0] s;
      s = tab >> dig;
      return s[0];
   endfunction

   function automatic logic [W-1:0] model_row(int dig, int y);
      logic [W-1:0] r, msb;
      bit sa, sb_, sc, sd, se, sf, sg, lit;
      int l, rr, t, b, m;
      l = MG; rr = W - 1 - MG; t = MG; b = H - 1 - MG; m = H / 2;
      sa = seg_on(10'b1111101101, dig);
      sb_ = seg_on(10'b1110011111, dig);
      sc = seg_on(10'b1111111011, dig);
      sd = seg_on(10'b1101101101, dig);
      se = seg_on(10'b0101000101, dig);
      sf = seg_on(10'b1101110001, dig);
      sg = seg_on(10'b1101111100, dig);
      r = '1;
      msb = {1'b1, {(W-1){1'b0}}};
      for (int x = 0; x < W; x++) begin
         lit = (sa && y == t && x >= l && x <= rr) || (sg && y == m && x >= l && x <= rr) ||
               (sd && y == b && x >= l && x <= rr) || (sf && x == l && y >= t && y <= m) ||
               (sb_ && x == rr && y >= t && y <= m) || (se && x == l && y >= m && y <= b) ||
               (sc && x == rr && y >= m && y <= b);
         if (lit) r = r & ~(msb >> x);
      end
      return r;
   endfunction

   task automatic push_frame(int dig);
      row_t e;
      for (int y = 0; y < H; y++) begin
         e.idx  = IW'(y);
         e.data = model_row(dig, y);
         e.last = (y == H - 1);
         sb.push_back(e);
      end
   endtask

   task automatic set_count(int n);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      incr  = 1'b1;
      repeat (n) @(negedge clk);
      incr  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({count, wrap, busy, row_valid, row_data, row_idx, row_last, frame_done} !==
          {4'd0, 1'b0, 1'b0, 1'b0, {W{1'b1}}, {IW{1'b0}}, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got count=%0d wrap=%b busy=%b valid=%b data=%h idx=%0d last=%b done=%b exp all idle, data=1ffffff",
                  count, wrap, busy, row_valid, row_data, row_idx, row_last, frame_done);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_counter();
      for (int i = 1; i <= 10; i++) begin
         incr = 1'b1;
         @(negedge clk);
         incr = 1'b0;
         checks++;
         if (count !== 4'(i % 10) || wrap !== (i == 10)) begin
            failures++;
            $display("FAIL cnt_step%0d got count=%0d wrap=%b exp count=%0d wrap=%b",
                     i, count, wrap, i % 10, i == 10);
         end
      end
      @(negedge clk);
      checks++;
      if (wrap !== 1'b0) begin
         failures++;
         $display("FAIL cnt_wrap_pulse got wrap=%b exp 0", wrap);
      end
      set_count(5);
      @(negedge clk);
      checks++;
      if (count !== 4'd5) begin
         failures++;
         $display("FAIL cnt_five got %0d exp 5", count);
      end
      incr  = 1'b1;
      clear = 1'b1;
      @(negedge clk);
      incr  = 1'b0;
      clear = 1'b0;
      checks++;
      if (count !== 4'd0 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL cnt_clear_prio got count=%0d wrap=%b exp count=0 wrap=0", count, wrap);
      end
   endtask

   // Digit 1 then digit 8 with ready held high; the second frame starts right after frame_done.
   task automatic test_back_to_back();
      row_t e;
      int dig;
      bit have;
      logic [W-1:0] spot;
      sb.delete();
      set_count(1);
      row_ready = 1'b1;
      start = 1'b1;
      push_frame(1);
      @(negedge clk);
      start = 1'b0;
      for (int f = 0; f < 2; f++) begin
         dig = (f == 0) ? 1 : 8;
         checks++;
         if (!(row_valid === 1'b1 && row_idx === '0 && busy === 1'b1 && frame_done === 1'b0)) begin
            failures++;
            $display("FAIL bb_latency d%0d got valid=%b idx=%0d busy=%b done=%b exp 1 0 1 0",
                     dig, row_valid, row_idx, busy, frame_done);
         end
         for (int cyc = 0; cyc < H; cyc++) begin
            checks++;
            if (row_valid !== 1'b1 || sb.size() == 0) begin
               failures++;
               $display("FAIL bb_valid d%0d cyc%0d got valid=%b exp 1", dig, cyc, row_valid);
            end else begin
               e = sb.pop_front();
               if ({row_idx, row_data, row_last} !== e) begin
                  failures++;
                  $display("FAIL bb_row d%0d got idx=%0d data=%h last=%b exp idx=%0d data=%h last=%b",
                           dig, row_idx, row_data, row_last, e.idx, e.data, e.last);
               end
               have = 1'b0;
               spot = '1;
               if (dig == 1) begin
                  have = 1'b1;
                  spot = (row_idx >= 3 && row_idx <= 21) ? 25'h1FFFFF7 : 25'h1FFFFFF;
               end else if (row_idx == 3 || row_idx == 12 || row_idx == 21) begin
                  have = 1'b1;
                  spot = 25'h1C00007;
               end else if (row_idx == 8) begin
                  have = 1'b1;
                  spot = 25'h1DFFFF7;
               end
               if (have) begin
                  checks++;
                  if (row_data !== spot) begin
                     failures++;
                     $display("FAIL bb_spot d%0d row%0d got %h exp %h", dig, row_idx, row_data, spot);
                  end
               end
            end
            if (f == 0) begin
               clear = (cyc == 0);
               incr  = (cyc >= 1 && cyc <= 8);
            end
            @(negedge clk);
         end
         checks++;
         if (!(frame_done === 1'b1 && busy === 1'b0 && row_valid === 1'b0)) begin
            failures++;
            $display("FAIL bb_done d%0d got done=%b busy=%b valid=%b exp 1 0 0",
                     dig, frame_done, busy, row_valid);
         end
         if (f == 0) begin
            checks++;
            if (count !== 4'd8) begin
               failures++;
               $display("FAIL bb_count got %0d exp 8", count);
            end
            start = 1'b1;
            push_frame(8);
         end
         @(negedge clk);
         start = 1'b0;
      end
      checks++;
      if (frame_done !== 1'b0) begin
         failures++;
         $display("FAIL bb_done_pulse got %b exp 0", frame_done);
      end
      row_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      row_t e;
      int acc = 0;
      int cyc = 0;
      logic pv = 1'b0;
      logic pr = 1'b0;
      logic [W-1:0] pd = '0;
      logic [IW-1:0] pi = '0;
      sb.delete();
      set_count(0);
      start = 1'b1;
      push_frame(0);
      @(negedge clk);
      start = 1'b0;
      while (acc < H && cyc < 400) begin
         if (pv && !pr) begin
            checks++;
            if (!(row_valid === 1'b1 && row_data === pd && row_idx === pi)) begin
               failures++;
               $display("FAIL bp_stable got valid=%b idx=%0d data=%h exp valid=1 idx=%0d data=%h",
                        row_valid, row_idx, row_data, pi, pd);
            end
         end
         row_ready = 1'($urandom_range(0, 1));
         if (row_valid === 1'b1 && row_ready) begin
            acc++;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL bp_extra got idx=%0d exp no row", row_idx);
            end else begin
               e = sb.pop_front();
               if ({row_idx, row_data, row_last} !== e) begin
                  failures++;
                  $display("FAIL bp_row got idx=%0d data=%h last=%b exp idx=%0d data=%h last=%b",
                           row_idx, row_data, row_last, e.idx, e.data, e.last);
               end
            end
            if (row_idx == 12) begin
               checks++;
               if (row_data !== 25'h1DFFFF7) begin
                  failures++;
                  $display("FAIL bp_row12 got %h exp 1dffff7", row_data);
               end
            end
         end
         pv = row_valid;
         pr = row_ready;
         pd = row_data;
         pi = row_idx;
         cyc++;
         @(negedge clk);
      end
      checks++;
      if (acc != H) begin
         failures++;
         $display("FAIL bp_timeout got %0d rows exp %0d", acc, H);
      end
      checks++;
      if (frame_done !== 1'b1) begin
         failures++;
         $display("FAIL bp_done got %b exp 1", frame_done);
      end
      row_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_snapshot();
      row_t e;
      int rows = 0;
      int dones = 0;
      sb.delete();
      set_count(3);
      row_ready = 1'b1;
      start = 1'b1;
      push_frame(3);
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (row_valid === 1'b1) begin
            rows++;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL snap_extra got idx=%0d exp no row", row_idx);
            end else begin
               e = sb.pop_front();
               if ({row_idx, row_data, row_last} !== e) begin
                  failures++;
                  $display("FAIL snap_row got idx=%0d data=%h exp idx=%0d data=%h",
                           row_idx, row_data, e.idx, e.data);
               end
            end
         end
         if (frame_done === 1'b1) dones++;
         incr  = (cyc == 0);
         start = (cyc == 2);
         @(negedge clk);
      end
      checks++;
      if (rows != H || dones != 1 || count !== 4'd4 || busy !== 1'b0) begin
         failures++;
         $display("FAIL snap_summary got rows=%0d dones=%0d count=%0d busy=%b exp %0d 1 4 0",
                  rows, dones, count, busy, H);
      end
      row_ready = 1'b0;
   endtask

   task automatic test_reset_midframe();
      row_t e;
      int dones = 0;
      sb.delete();
      set_count(2);
      row_ready = 1'b1;
      start = 1'b1;
      push_frame(2);
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc <= 10; cyc++) begin
         e = sb.pop_front();
         checks++;
         if (row_valid !== 1'b1 || {row_idx, row_data, row_last} !== e) begin
            failures++;
            $display("FAIL rst_pre_row got valid=%b idx=%0d data=%h exp valid=1 idx=%0d data=%h",
                     row_valid, row_idx, row_data, e.idx, e.data);
         end
         if (cyc < 10) @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (row_valid !== 1'b0 || busy !== 1'b0 || count !== 4'd0 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL rst_abort got valid=%b busy=%b count=%0d done=%b exp 0 0 0 0",
                  row_valid, busy, count, frame_done);
      end
      sb.delete();
      repeat (3) begin
         @(negedge clk);
         if (frame_done === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin
         failures++;
         $display("FAIL rst_no_done got %0d pulses exp 0", dones);
      end
      start = 1'b1;
      push_frame(0);
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < H; cyc++) begin
         e = sb.pop_front();
         checks++;
         if (row_valid !== 1'b1 || {row_idx, row_data, row_last} !== e) begin
            failures++;
            $display("FAIL rst_fresh_row got valid=%b idx=%0d data=%h exp valid=1 idx=%0d data=%h",
                     row_valid, row_idx, row_data, e.idx, e.data);
         end
         @(negedge clk);
      end
      checks++;
      if (frame_done !== 1'b1) begin
         failures++;
         $display("FAIL rst_fresh_done got %b exp 1", frame_done);
      end
      row_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      incr = 1'b0;
      clear = 1'b0;
      start = 1'b0;
      row_ready = 1'b0;
      test_reset();
      test_counter();
      test_back_to_back();
      test_backpressure();
      test_snapshot();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
